// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection: 1-cycle capture, bubble on flush or stall.
// On a load-use hazard, PC and IF/ID are held for one cycle. A flush overrides the stall.
module id_ex_stage_reg #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [4:0]      if_id_rs1,
   input  logic [4:0]      if_id_rs2,
   input  logic [4:0]      if_id_rd,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_pc,
   input  logic [2:0]      id_funct3,
   input  logic            id_funct7b5,
   input  logic [7:0]      id_ctrl,
   input  logic            flush,
   output logic [4:0]      id_ex_rs1,
   output logic [4:0]      id_ex_rs2,
   output logic [4:0]      id_ex_rd,
   output logic [XLEN-1:0] id_ex_rs1_data,
   output logic [XLEN-1:0] id_ex_rs2_data,
   output logic [XLEN-1:0] id_ex_imm,
   output logic [XLEN-1:0] id_ex_pc,
   output logic [2:0]      id_ex_funct3,
   output logic            id_ex_funct7b5,
   output logic [7:0]      id_ex_ctrl,
   output logic            id_ex_valid,
   output logic            pc_write,
   output logic            if_id_write,
   output logic [CNT_W-1:0] stall_count
);

   logic [4:0]       r_rs1, r_rs2, r_rd;
   logic [XLEN-1:0]  r_rs1_data, r_rs2_data, r_imm, r_pc;
   logic [2:0]       r_funct3;
   logic             r_funct7b5;
   logic [7:0]       r_ctrl;
   logic             r_valid;
   logic [CNT_W-1:0] r_stall_count;

   logic w_memread;
   logic w_load_use;
   logic w_hazard_stall;
   logic w_bubble;

   // id_ctrl packing: {regwrite, memread, memwrite, memtoreg, branch, alusrc, aluop[1:0]}
   assign w_memread = r_ctrl[6];
   assign w_load_use = w_memread && (r_rd != 5'd0) &&
                       ((id_uses_rs1 && (r_rd == if_id_rs1)) ||
                        (id_uses_rs2 && (r_rd == if_id_rs2)));
   assign w_hazard_stall = w_load_use && !flush;
   assign w_bubble       = flush || w_hazard_stall;

   assign pc_write    = !w_hazard_stall;
   assign if_id_write = !w_hazard_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rs1         <= '0;
         r_rs2         <= '0;
         r_rd          <= '0;
         r_rs1_data    <= '0;
         r_rs2_data    <= '0;
         r_imm         <= '0;
         r_pc          <= '0;
         r_funct3      <= '0;
         r_funct7b5    <= 1'b0;
         r_ctrl        <= '0;
         r_valid       <= 1'b0;
         r_stall_count <= '0;
      end else begin
         if (w_bubble) begin
            // Zeroed indices keep the forwarding unit from matching a bubble.
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_ctrl     <= '0;
            r_valid    <= 1'b0;
         end else begin
            r_rs1      <= if_id_rs1;
            r_rs2      <= if_id_rs2;
            r_rd       <= if_id_rd;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_pc       <= id_pc;
            r_funct3   <= id_funct3;
            r_funct7b5 <= id_funct7b5;
            r_ctrl     <= id_ctrl;
            r_valid    <= 1'b1;
         end
         if (w_hazard_stall && (r_stall_count != {CNT_W{1'b1}}))
            r_stall_count <= r_stall_count + 1'b1;
      end
   end

   assign id_ex_rs1      = r_rs1;
   assign id_ex_rs2      = r_rs2;
   assign id_ex_rd       = r_rd;
   assign id_ex_rs1_data = r_rs1_data;
   assign id_ex_rs2_data = r_rs2_data;
   assign id_ex_imm      = r_imm;
   assign id_ex_pc       = r_pc;
   assign id_ex_funct3   = r_funct3;
   assign id_ex_funct7b5 = r_funct7b5;
   assign id_ex_ctrl     = r_ctrl;
   assign id_ex_valid    = r_valid;
   assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus random traffic against a reference model.
// A second instance with a 2-bit counter exercises saturation under identical stimulus.
module tb_id_ex_stage_reg;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [4:0]      if_id_rs1, if_id_rs2, if_id_rd;
   logic            id_uses_rs1, id_uses_rs2;
   logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic [2:0]      id_funct3;
   logic            id_funct7b5;
   logic [7:0]      id_ctrl;
   logic            flush;

   logic [4:0]      id_ex_rs1, id_ex_rs2, id_ex_rd;
   logic [XLEN-1:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm, id_ex_pc;
   logic [2:0]      id_ex_funct3;
   logic            id_ex_funct7b5;
   logic [7:0]      id_ex_ctrl;
   logic            id_ex_valid, pc_write, if_id_write;
   logic [15:0]     stall_count;

   logic [4:0]      s_rs1, s_rs2, s_rd;
   logic [XLEN-1:0] s_rs1_data, s_rs2_data, s_imm, s_pc;
   logic [2:0]      s_funct3;
   logic            s_funct7b5;
   logic [7:0]      s_ctrl;
   logic            s_valid, s_pc_write, s_if_id_write;
   logic [1:0]      s_stall_count;

   always #5 clk = ~clk;

   id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_pc(id_pc), .id_funct3(id_funct3),
      .id_funct7b5(id_funct7b5), .id_ctrl(id_ctrl), .flush(flush),
      .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
      .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
      .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc), .id_ex_funct3(id_ex_funct3),
      .id_ex_funct7b5(id_ex_funct7b5), .id_ex_ctrl(id_ex_ctrl),
      .id_ex_valid(id_ex_valid), .pc_write(pc_write),
      .if_id_write(if_id_write), .stall_count(stall_count)
   );

   id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_pc(id_pc), .id_funct3(id_funct3),
      .id_funct7b5(id_funct7b5), .id_ctrl(id_ctrl), .flush(flush),
      .id_ex_rs1(s_rs1), .id_ex_rs2(s_rs2), .id_ex_rd(s_rd),
      .id_ex_rs1_data(s_rs1_data), .id_ex_rs2_data(s_rs2_data),
      .id_ex_imm(s_imm), .id_ex_pc(s_pc), .id_ex_funct3(s_funct3),
      .id_ex_funct7b5(s_funct7b5), .id_ex_ctrl(s_ctrl),
      .id_ex_valid(s_valid), .pc_write(s_pc_write),
      .if_id_write(s_if_id_write), .stall_count(s_stall_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the instruction EX is expected to hold, and the bubble counts.
   logic [4:0]      m_rs1, m_rs2, m_rd;
   logic [XLEN-1:0] m_rs1_data, m_rs2_data, m_imm, m_pc;
   logic [2:0]      m_funct3;
   logic            m_funct7b5;
   logic [7:0]      m_ctrl;
   logic            m_valid;
   int              m_cnt, m_cnt_sat;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_rs1 = '0; m_rs2 = '0; m_rd = '0;
      m_rs1_data = '0; m_rs2_data = '0; m_imm = '0; m_pc = '0;
      m_funct3 = '0; m_funct7b5 = 1'b0; m_ctrl = '0; m_valid = 1'b0;
   endtask

   function automatic logic model_load_use();
      logic loads;
      logic hit1, hit2;
      loads = m_ctrl[6] && (m_rd != 0);
      hit1  = id_uses_rs1 && (if_id_rs1 == m_rd);
      hit2  = id_uses_rs2 && (if_id_rs2 == m_rd);
      return loads && (hit1 || hit2);
   endfunction

   task automatic check_outs(input string pfx);
      chk({pfx, ".rs1"},     id_ex_rs1, m_rs1);
      chk({pfx, ".rs2"},     id_ex_rs2, m_rs2);
      chk({pfx, ".rd"},      id_ex_rd, m_rd);
      chk({pfx, ".rs1d"},    id_ex_rs1_data, m_rs1_data);
      chk({pfx, ".rs2d"},    id_ex_rs2_data, m_rs2_data);
      chk({pfx, ".imm"},     id_ex_imm, m_imm);
      chk({pfx, ".pc"},      id_ex_pc, m_pc);
      chk({pfx, ".f3"},      id_ex_funct3, m_funct3);
      chk({pfx, ".f7b5"},    id_ex_funct7b5, m_funct7b5);
      chk({pfx, ".ctrl"},    id_ex_ctrl, m_ctrl);
      chk({pfx, ".valid"},   id_ex_valid, m_valid);
      chk({pfx, ".cnt"},     stall_count, m_cnt);
      chk({pfx, ".cnt_sat"}, s_stall_count, m_cnt_sat);
      chk({pfx, ".sat_ctrl"}, s_ctrl, m_ctrl);
   endtask

   // One pipeline cycle: drive ID at negedge, check stall outputs, then check EX after the edge.
   task automatic step(input string tag, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic u1, input logic u2,
                       input logic [7:0] c, input logic f, input logic [31:0] imm);
      logic stall;
      @(negedge clk);
      if_id_rs1 = a; if_id_rs2 = b; if_id_rd = d;
      id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = c; flush = f; id_imm = imm;
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_pc = $urandom;
      id_funct3 = 3'($urandom); id_funct7b5 = 1'($urandom);
      #1;
      stall = model_load_use() && !f;
      chk({tag, ".pc_write"}, pc_write, !stall);
      chk({tag, ".if_id_write"}, if_id_write, !stall);
      @(posedge clk);
      if (f || stall) begin
         model_clear();
      end else begin
         m_rs1 = a; m_rs2 = b; m_rd = d;
         m_rs1_data = id_rs1_data; m_rs2_data = id_rs2_data;
         m_imm = imm; m_pc = id_pc; m_funct3 = id_funct3; m_funct7b5 = id_funct7b5;
         m_ctrl = c; m_valid = 1'b1;
      end
      if (stall) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt_sat < 3) m_cnt_sat++;
      end
      #1;
      check_outs(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      if_id_rs1 = '0; if_id_rs2 = '0; if_id_rd = '0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_pc = '0;
      id_funct3 = '0; id_funct7b5 = 1'b0; id_ctrl = '0; flush = 1'b0;
      model_clear();
      m_cnt = 0; m_cnt_sat = 0;
      #12;
      check_outs("reset");
      chk("reset.pc_write", pc_write, 1'b1);
      chk("reset.if_id_write", if_id_write, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Normal capture
      step("normal", 5'd4, 5'd3, 5'd9, 1'b1, 1'b1, 8'h80, 1'b0, 32'h10);
      chk("normal.ctrl80", id_ex_ctrl, 8'h80);
      chk("normal.imm10", id_ex_imm, 32'h10);

      // Load-use: lw x5, then consumer of x5 stalls once, then advances
      step("lw", 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'hC0, 1'b0, 32'h4);
      step("lu_stall", 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 8'h80, 1'b0, 32'h0);
      chk("lu_stall.bubble_valid", id_ex_valid, 1'b0);
      step("lu_adv", 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 8'h80, 1'b0, 32'h0);
      chk("lu_adv.valid", id_ex_valid, 1'b1);
      chk("lu_adv.count", stall_count, 16'd1);

      // No false stalls
      step("lw2", 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'hC0, 1'b0, 32'h0);
      step("unused_rs2", 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 8'h80, 1'b0, 32'h0);
      step("lw_x0", 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 8'h40, 1'b0, 32'h0);
      step("rd_x0", 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 8'h80, 1'b0, 32'h0);
      step("alu_rd5", 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 8'h80, 1'b0, 32'h0);
      step("non_load", 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 8'h80, 1'b0, 32'h0);
      chk("no_false.count", stall_count, 16'd1);

      // Flush beats load-use
      step("lw3", 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'hC0, 1'b0, 32'h0);
      step("flush_lu", 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 8'h80, 1'b1, 32'h0);
      chk("flush_lu.count", stall_count, 16'd1);

      // Reset asserted between edges during a stall
      step("lw4", 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'hC0, 1'b0, 32'h0);
      @(negedge clk);
      if_id_rs1 = 5'd5; id_uses_rs1 = 1'b1; flush = 1'b0;
      #1;
      chk("mid.pc_write_pre", pc_write, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      model_clear();
      m_cnt = 0; m_cnt_sat = 0;
      check_outs("mid_reset");
      chk("mid.pc_write", pc_write, 1'b1);
      chk("mid.if_id_write", if_id_write, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Saturation of the 2-bit counter over five separate stalls
      for (int i = 0; i < 5; i++) begin
         step("sat_lw", 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'hC0, 1'b0, 32'h0);
         step("sat_use", 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 8'h80, 1'b0, 32'h0);
         chk("sat.seq", s_stall_count, (i < 3) ? (i + 1) : 3);
      end

      // Random traffic with small register indices to provoke hazards
      for (int i = 0; i < 400; i++) begin
         logic [7:0] c;
         c = 8'($urandom);
         if ($urandom_range(0, 1) == 0) c[6] = 1'b1;
         step("rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), c,
              ($urandom_range(0, 7) == 0), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
